// File: rtl/mem_march_controller_if.sv
// Bus between the march BIST sequencer and its surroundings: command/status
// from the top-level logic plus the memory-array access signals.
interface mem_march_controller_if #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic                 stop_on_fail;
  logic [DATA_BITS-1:0] bg;
  logic                 busy;
  logic                 done;
  logic                 fail;
  logic [ADDR_BITS-1:0] fail_addr;
  logic [2:0]           fail_elem;
  logic [DATA_BITS-1:0] fail_data;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 mem_we;
  logic [DATA_BITS-1:0] mem_rdata;

  modport slave (
    input  start, stop_on_fail, bg, mem_rdata,
    output busy, done, fail, fail_addr, fail_elem, fail_data,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output start, stop_on_fail, bg, mem_rdata,
    input  busy, done, fail, fail_addr, fail_elem, fail_data,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_march_controller.sv
// March C- self-test sequencer for the latch/DFF memory array.
// Elements: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 dn(r0,w1) E4 dn(r1,w0) E5 up(r0).
module mem_march_controller #(
  parameter int ADDR_BITS            = 4,
  parameter int DATA_BITS            = 8,
  parameter int PRE_POST_WRITE_DELAY = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  mem_march_controller_if.slave bus
);
  // state    | meaning
  // IDLE     | waiting for start
  // RD_ADDR  | present read address
  // RD_CHECK | compare read data with expected pattern
  // WR_SETUP | addr/wdata valid, we low (delayed write only)
  // WR_PULSE | write enable high
  // WR_HOLD  | addr/wdata held, we low (delayed write only)
  // DONE     | one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_CHECK, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_BITS-1:0] ONE_ADDR   = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam bit                   DELAYED_WR = (PRE_POST_WRITE_DELAY != 0);
  localparam state_t               WR_FIRST   = DELAYED_WR ? WR_SETUP : WR_PULSE;
  localparam logic                 WE_FIRST   = DELAYED_WR ? 1'b0 : 1'b1;

  state_t               r_state;
  logic [2:0]           r_elem;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_bg;
  logic                 r_stop;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_fail;
  logic [ADDR_BITS-1:0] r_fail_addr;
  logic [2:0]           r_fail_elem;
  logic [DATA_BITS-1:0] r_fail_data;
  logic [ADDR_BITS-1:0] r_mem_addr;
  logic [DATA_BITS-1:0] r_mem_wdata;
  logic                 r_mem_we;

  logic                 w_desc;
  logic                 w_last;
  logic [2:0]           w_nxt_elem;
  logic [ADDR_BITS-1:0] w_nxt_addr;
  logic                 w_end;
  logic [DATA_BITS-1:0] w_wr_val;
  logic [DATA_BITS-1:0] w_rd_exp;
  logic                 w_mismatch;
  logic                 w_word_done;

  always_comb begin
    w_desc     = (r_elem == 3'd3) || (r_elem == 3'd4);
    w_last     = w_desc ? (r_addr == '0) : (r_addr == LAST_ADDR);
    w_nxt_elem = w_last ? (r_elem + 3'd1) : r_elem;
    // Address wraps only when crossing into the next element.
    if (w_last)
      w_nxt_addr = ((w_nxt_elem == 3'd3) || (w_nxt_elem == 3'd4)) ? LAST_ADDR : '0;
    else
      w_nxt_addr = w_desc ? (r_addr - ONE_ADDR) : (r_addr + ONE_ADDR);
    w_end      = w_last && (r_elem == 3'd5);
    w_wr_val   = ((r_elem == 3'd1) || (r_elem == 3'd3)) ? ~r_bg : r_bg;
    w_rd_exp   = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? ~r_bg : r_bg;
    w_mismatch = (bus.mem_rdata != w_rd_exp);
    w_word_done = ((r_state == WR_PULSE) && !DELAYED_WR) ||
                  (r_state == WR_HOLD) ||
                  ((r_state == RD_CHECK) && (r_elem == 3'd5) && !(w_mismatch && r_stop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_elem      <= '0;
      r_addr      <= '0;
      r_bg        <= '0;
      r_stop      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_data <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_bg        <= bus.bg;
            r_stop      <= bus.stop_on_fail;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_data <= '0;
            r_elem      <= '0;
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= bus.bg;
            r_mem_we    <= WE_FIRST;
            r_busy      <= 1'b1;
            r_state     <= WR_FIRST;
          end
        end
        RD_ADDR: r_state <= RD_CHECK;
        RD_CHECK: begin
          if (w_mismatch && !r_fail) begin
            r_fail      <= 1'b1;
            r_fail_addr <= r_addr;
            r_fail_elem <= r_elem;
            r_fail_data <= bus.mem_rdata;
          end
          if (w_mismatch && r_stop) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_elem != 3'd5) begin
            r_state     <= WR_FIRST;
            r_mem_wdata <= w_wr_val;
            r_mem_we    <= WE_FIRST;
          end
        end
        WR_SETUP: begin
          r_state  <= WR_PULSE;
          r_mem_we <= 1'b1;
        end
        WR_PULSE: begin
          r_mem_we <= 1'b0;
          if (DELAYED_WR) r_state <= WR_HOLD;
        end
        WR_HOLD: r_mem_we <= 1'b0;
        DONE:    r_state  <= IDLE;
        default: r_state  <= IDLE;
      endcase

      // Word finished: advance address/element and launch the next word's first op.
      if (w_word_done) begin
        if (w_end) begin
          r_state  <= DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_mem_we <= 1'b0;
        end else begin
          r_elem     <= w_nxt_elem;
          r_addr     <= w_nxt_addr;
          r_mem_addr <= w_nxt_addr;
          if (w_nxt_elem == 3'd0) begin
            r_state     <= WR_FIRST;
            r_mem_wdata <= r_bg;
            r_mem_we    <= WE_FIRST;
          end else begin
            r_state  <= RD_ADDR;
            r_mem_we <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.fail      = r_fail;
  assign bus.fail_addr = r_fail_addr;
  assign bus.fail_elem = r_fail_elem;
  assign bus.fail_data = r_fail_data;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
endmodule

// File: tb/tb_mem_march_controller.sv
// Bench for mem_march_controller: one DUT per write-delay setting sharing an
// array model with injectable faults, checked against a March C- walk model.
module tb_mem_march_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_march_controller_if #(.ADDR_BITS(4), .DATA_BITS(8)) if0 ();
  mem_march_controller_if #(.ADDR_BITS(4), .DATA_BITS(8)) if1 ();

  mem_march_controller #(.ADDR_BITS(4), .DATA_BITS(8), .PRE_POST_WRITE_DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mem_march_controller #(.ADDR_BITS(4), .DATA_BITS(8), .PRE_POST_WRITE_DELAY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int checks = 0;
  int errors = 0;

  int sel = 0;
  int fault_kind = 0;  // 0 none, 1 stuck-at-1 bit, 2 down-transition coupling 9->8
  int f_addr = 0;
  int f_bit = 0;
  logic [7:0] mem [16];
  logic [7:0] mm [16];

  logic [7:0] r0, r1;
  always_comb begin
    r0 = mem[if0.mem_addr];
    if (fault_kind == 1 && int'(if0.mem_addr) == f_addr) r0[f_bit] = 1'b1;
    r1 = mem[if1.mem_addr];
    if (fault_kind == 1 && int'(if1.mem_addr) == f_addr) r1[f_bit] = 1'b1;
  end
  assign if0.mem_rdata = r0;
  assign if1.mem_rdata = r1;

  logic       m_busy, m_done, m_we, m_fail;
  logic [3:0] m_addr, m_faddr;
  logic [2:0] m_felem;
  logic [7:0] m_wdata, m_fdata;
  always_comb begin
    if (sel != 0) begin
      m_busy = if1.busy; m_done = if1.done; m_we = if1.mem_we; m_fail = if1.fail;
      m_addr = if1.mem_addr; m_wdata = if1.mem_wdata;
      m_faddr = if1.fail_addr; m_felem = if1.fail_elem; m_fdata = if1.fail_data;
    end else begin
      m_busy = if0.busy; m_done = if0.done; m_we = if0.mem_we; m_fail = if0.fail;
      m_addr = if0.mem_addr; m_wdata = if0.mem_wdata;
      m_faddr = if0.fail_addr; m_felem = if0.fail_elem; m_fdata = if0.fail_data;
    end
  end

  // Array model: writes land on the clock edge that ends a mem_we cycle.
  always @(posedge clk) begin
    if (m_we) begin
      if (fault_kind == 2 && m_addr == 4'd9 && ((mem[9] & ~m_wdata) != 8'h00))
        mem[8] <= ~mem[8];
      mem[m_addr] <= m_wdata;
    end
  end

  logic [11:0] wq[$], ewq[$];
  logic [3:0]  aq[$], eaq[$];
  int   busy_cnt, done_cnt, bad_cnt, stab_err;
  logic mon_en = 1'b0;
  logic p_we = 1'b0;
  logic [3:0] p_addr = '0;
  logic [7:0] p_wdata = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_busy) begin busy_cnt++; aq.push_back(m_addr); end
      if (m_done) done_cnt++;
      if (m_done && m_busy) bad_cnt++;
      if (m_we) wq.push_back({m_addr, m_wdata});
      if (sel != 0) begin
        if (m_we && (p_we || m_addr !== p_addr || m_wdata !== p_wdata)) stab_err++;
        if (p_we && (m_we || m_addr !== p_addr || m_wdata !== p_wdata)) stab_err++;
      end
    end
    p_we = m_we; p_addr = m_addr; p_wdata = m_wdata;
  end

  function automatic int q_diff_w();
    int n = (wq.size() > ewq.size()) ? wq.size() - ewq.size() : ewq.size() - wq.size();
    for (int i = 0; i < wq.size() && i < ewq.size(); i++) if (wq[i] !== ewq[i]) n++;
    return n;
  endfunction

  function automatic int q_diff_a();
    int n = (aq.size() > eaq.size()) ? aq.size() - eaq.size() : eaq.size() - aq.size();
    for (int i = 0; i < aq.size() && i < eaq.size(); i++) if (aq[i] !== eaq[i]) n++;
    return n;
  endfunction

  task automatic drive(input int d, input logic s, input logic [7:0] b, input logic sof);
    if (d != 0) begin if1.start = s; if1.bg = b; if1.stop_on_fail = sof; end
    else        begin if0.start = s; if0.bg = b; if0.stop_on_fail = sof; end
  endtask

  // March C- walked directly over a behavioural array copy (mm).
  task automatic model(input int d, input logic [7:0] b, input logic sof,
                       output int e_busy, output logic e_fail, output int e_faddr,
                       output int e_felem, output logic [7:0] e_fdata);
    int w = (d != 0) ? 3 : 1;
    int a;
    logic [7:0] v, x;
    e_busy = 0; e_fail = 1'b0; e_faddr = 0; e_felem = 0; e_fdata = 8'h00;
    ewq.delete(); eaq.delete();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 16; k++) begin
        a = (e == 3 || e == 4) ? 15 - k : k;
        if (e > 0) begin
          x = (e == 2 || e == 4) ? ~b : b;
          v = mm[a];
          if (fault_kind == 1 && a == f_addr) v[f_bit] = 1'b1;
          e_busy += 2;
          eaq.push_back(a[3:0]); eaq.push_back(a[3:0]);
          if (v !== x) begin
            if (!e_fail) begin e_fail = 1'b1; e_faddr = a; e_felem = e; e_fdata = v; end
            if (sof) return;
          end
        end
        if (e < 5) begin
          x = (e == 1 || e == 3) ? ~b : b;
          if (fault_kind == 2 && a == 9 && ((mm[9] & ~x) != 8'h00)) mm[8] = ~mm[8];
          mm[a] = x;
          ewq.push_back({a[3:0], x});
          for (int j = 0; j < w; j++) eaq.push_back(a[3:0]);
          e_busy += w;
        end
      end
    end
  endtask

  task automatic run(input int d, input logic [7:0] b, input logic sof,
                     input int restart_at, output int timed_out);
    int n;
    sel = d;
    busy_cnt = 0; done_cnt = 0; bad_cnt = 0; stab_err = 0;
    aq.delete(); wq.delete();
    @(negedge clk);
    drive(d, 1'b1, b, sof);
    mon_en = 1'b1;
    @(negedge clk);
    drive(d, 1'b0, b, sof);
    n = 0; timed_out = 1;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      drive(d, (n == restart_at), ~b, ~sof);
      if (m_done) begin timed_out = 0; break; end
    end
    drive(d, 1'b0, b, sof);
    @(negedge clk); @(negedge clk);
    mon_en = 1'b0;
  endtask

  // Full scenario: model, run, then compare the common observables.
  task automatic scenario(input string nm, input int d, input logic [7:0] b,
                          input logic sof, input int restart_at,
                          output int e_busy, output logic e_fail, output int e_faddr,
                          output int e_felem, output logic [7:0] e_fdata);
    int to;
    mm = mem;
    model(d, b, sof, e_busy, e_fail, e_faddr, e_felem, e_fdata);
    run(d, b, sof, restart_at, to);
    checks++;
    if (to != 0) begin errors++; $display("FAIL %s timeout: no done within 2000 cycles", nm); end
    checks++;
    if (busy_cnt != e_busy) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", nm, busy_cnt, e_busy); end
    checks++;
    if (done_cnt != 1 || bad_cnt != 0) begin errors++; $display("FAIL %s done_pulse: got %0d cycles (%0d with busy) expected 1 (0)", nm, done_cnt, bad_cnt); end
    checks++;
    if (m_fail !== e_fail) begin errors++; $display("FAIL %s fail: got %0b expected %0b", nm, m_fail, e_fail); end
    if (e_fail) begin
      checks++;
      if (int'(m_faddr) != e_faddr || int'(m_felem) != e_felem || m_fdata !== e_fdata) begin
        errors++;
        $display("FAIL %s fail_info: got addr %0d elem %0d data %02h expected addr %0d elem %0d data %02h",
                 nm, m_faddr, m_felem, m_fdata, e_faddr, e_felem, e_fdata);
      end
    end
    checks++;
    if (q_diff_w() != 0) begin errors++; $display("FAIL %s write_seq: got %0d writes expected %0d, %0d differences", nm, wq.size(), ewq.size(), q_diff_w()); end
  endtask

  task automatic test_reset();
    checks++;
    if ({if0.busy, if0.done, if0.fail, if0.fail_addr, if0.fail_elem, if0.fail_data,
         if0.mem_addr, if0.mem_wdata, if0.mem_we} !== 40'd0) begin
      errors++; $display("FAIL reset_d0: outputs not zero, busy %0b we %0b", if0.busy, if0.mem_we);
    end
    checks++;
    if ({if1.busy, if1.done, if1.fail, if1.fail_addr, if1.fail_elem, if1.fail_data,
         if1.mem_addr, if1.mem_wdata, if1.mem_we} !== 40'd0) begin
      errors++; $display("FAIL reset_d1: outputs not zero, busy %0b we %0b", if1.busy, if1.mem_we);
    end
  endtask

  task automatic test_fault_free();
    int eb, ea, ee; logic ef; logic [7:0] ed; int bad;
    fault_kind = 0;
    foreach (mem[i]) mem[i] = 8'h3C;
    scenario("ff_d0", 0, 8'h00, 1'b0, 0, eb, ef, ea, ee, ed);
    checks++;
    if (busy_cnt != 240) begin errors++; $display("FAIL ff_d0 busy_240: got %0d expected 240", busy_cnt); end
    checks++;
    if (q_diff_a() != 0) begin errors++; $display("FAIL ff_d0 addr_order: %0d differences over %0d cycles", q_diff_a(), aq.size()); end
    bad = 0;
    foreach (mem[i]) if (mem[i] !== 8'h00) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ff_d0 array_final: got %0d non-00 words expected 0", bad); end

    scenario("ff_d1", 1, 8'hA5, 1'b0, 0, eb, ef, ea, ee, ed);
    checks++;
    if (busy_cnt != 400) begin errors++; $display("FAIL ff_d1 busy_400: got %0d expected 400", busy_cnt); end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL ff_d1 write_stability: got %0d violations expected 0", stab_err); end
    checks++;
    if (q_diff_a() != 0) begin errors++; $display("FAIL ff_d1 addr_order: %0d differences over %0d cycles", q_diff_a(), aq.size()); end
    bad = 0;
    foreach (mem[i]) if (mem[i] !== 8'hA5) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ff_d1 array_final: got %0d non-A5 words expected 0", bad); end
  endtask

  task automatic test_stuck_at();
    int eb, ea, ee; logic ef; logic [7:0] ed;
    fault_kind = 1; f_addr = 5; f_bit = 3;
    scenario("sa1_nostop", 0, 8'h00, 1'b0, 0, eb, ef, ea, ee, ed);
    checks++;
    if (!m_fail || m_felem != 3'd1 || m_faddr != 4'd5 || m_fdata !== 8'h08) begin
      errors++; $display("FAIL sa1_nostop info: got fail %0b elem %0d addr %0d data %02h expected 1 1 5 08", m_fail, m_felem, m_faddr, m_fdata);
    end
    checks++;
    if (busy_cnt != 240) begin errors++; $display("FAIL sa1_nostop busy_240: got %0d expected 240", busy_cnt); end

    scenario("sa1_stop", 0, 8'h00, 1'b1, 0, eb, ef, ea, ee, ed);
    checks++;
    if (busy_cnt != 33) begin errors++; $display("FAIL sa1_stop busy_33: got %0d expected 33", busy_cnt); end
    checks++;
    if (wq.size() != 21 || m_faddr != 4'd5) begin errors++; $display("FAIL sa1_stop writes_addr: got %0d writes addr %0d expected 21 writes addr 5", wq.size(), m_faddr); end
    fault_kind = 0;
  endtask

  task automatic test_coupling();
    int eb, ea, ee; logic ef; logic [7:0] ed;
    fault_kind = 2;
    foreach (mem[i]) mem[i] = 8'h00;
    scenario("cpl", 0, 8'h00, 1'b0, 0, eb, ef, ea, ee, ed);
    checks++;
    if (!m_fail || m_felem != 3'd3 || m_faddr != 4'd8) begin
      errors++; $display("FAIL cpl first_fail: got fail %0b elem %0d addr %0d expected 1 3 8", m_fail, m_felem, m_faddr);
    end
    fault_kind = 0;
  endtask

  task automatic test_random();
    int eb, ea, ee, d; logic ef, sof; logic [7:0] ed, b;
    for (int it = 0; it < 6; it++) begin
      d = int'($urandom_range(1, 0));
      b = 8'($urandom);
      sof = 1'($urandom);
      fault_kind = int'($urandom_range(1, 0));
      f_addr = int'($urandom_range(15, 0));
      f_bit = int'($urandom_range(7, 0));
      foreach (mem[i]) mem[i] = 8'($urandom);
      scenario($sformatf("rnd%0d", it), d, b, sof, 0, eb, ef, ea, ee, ed);
    end
    fault_kind = 0;
  endtask

  task automatic test_reset_mid_write();
    int n;
    sel = 1; done_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    drive(1, 1'b1, 8'h5A, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);
    drive(1, 1'b0, 8'h5A, 1'b0);
    n = 0;
    while (!if1.mem_we && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!if1.mem_we) begin errors++; $display("FAIL rst_mid wait_we: got we %0b expected 1 within 100 cycles", if1.mem_we); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({if1.busy, if1.done, if1.fail, if1.fail_addr, if1.fail_elem, if1.fail_data,
         if1.mem_addr, if1.mem_wdata, if1.mem_we} !== 40'd0) begin
      errors++; $display("FAIL rst_mid async_clear: got we %0b busy %0b addr %0d expected all 0", if1.mem_we, if1.busy, if1.mem_addr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (done_cnt != 0 || if1.busy !== 1'b0) begin errors++; $display("FAIL rst_mid no_done: got %0d done pulses busy %0b expected 0 0", done_cnt, if1.busy); end
  endtask

  task automatic test_back_to_back();
    int eb, ea, ee; logic ef; logic [7:0] ed;
    fault_kind = 0;
    scenario("restart_busy", 0, 8'hC3, 1'b0, 50, eb, ef, ea, ee, ed);
    checks++;
    if (busy_cnt != 240) begin errors++; $display("FAIL restart_busy len: got %0d expected 240", busy_cnt); end
    scenario("restart_d1", 1, 8'h0F, 1'b0, 200, eb, ef, ea, ee, ed);
  endtask

  initial begin
    if0.start = 1'b0; if0.stop_on_fail = 1'b0; if0.bg = 8'h00;
    if1.start = 1'b0; if1.stop_on_fail = 1'b0; if1.bg = 8'h00;
    foreach (mem[i]) mem[i] = 8'h00;
    rst_n = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_fault_free();
    test_stuck_at();
    test_coupling();
    test_random();
    test_reset_mid_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_march_controller.md
Name: mem_march_controller

Overview:
- Built-in self-test sequencer for the on-chip latch/DFF memory array.
- Runs a March C- test over all 2^ADDR_BITS words, driving the array's address, write-data and write-enable inputs and checking read data.
- Sits between the top-level serial command logic and the memory array. The top level muxes the array inputs to this block while busy=1.
- Honours the latch-element pre/post write delay so address and data are stable around every write-enable pulse.

Parameters:
- ADDR_BITS, 4, memory address width; word count N = 2^ADDR_BITS.
- DATA_BITS, 8, memory word width.
- PRE_POST_WRITE_DELAY, 0, 1 = each write takes setup/pulse/hold cycles (3 cycles); 0 = single-cycle write.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a test when sampled high in IDLE.
- stop_on_fail  in  1  1 = end the test at the first mismatch; sampled with start.
- bg  in  DATA_BITS  background pattern; "0" = bg, "1" = ~bg; sampled with start.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at test end.
- fail  out  1  sticky mismatch flag; cleared on the next accepted start.
- fail_addr  out  ADDR_BITS  address of the first mismatch.
- fail_elem  out  3  march element index (0-5) of the first mismatch.
- fail_data  out  DATA_BITS  read data at the first mismatch.
- mem_addr  out  ADDR_BITS  array address, registered.
- mem_wdata  out  DATA_BITS  array write data, registered.
- mem_we  out  1  array write enable, registered.
- mem_rdata  in  DATA_BITS  array read data; combinational from the array for the presented mem_addr.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset is asynchronous, so mem_we drops immediately, including mid-write. A reset mid-test aborts the test with no done pulse.
- March C- elements:
  - E0 ascending (w0)
  - E1 ascending (r0, w1)
  - E2 ascending (r1, w0)
  - E3 descending (r0, w1)
  - E4 descending (r1, w0)
  - E5 ascending (r0)
- Ascending runs 0..N-1; descending runs N-1..0. The address counter wraps only at element boundaries.
- States: IDLE, RD_ADDR, RD_CHECK, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - On start=1, latch bg and stop_on_fail, clear fail/fail_addr/fail_elem/fail_data, set element=0 and address=0.
  - Enter the first operation next cycle; busy=1 from that cycle.
- Read, 2 cycles:
  - RD_ADDR drives mem_addr.
  - RD_CHECK holds mem_addr and compares mem_rdata with the expected value (bg or ~bg).
  - On the first mismatch only: fail=1, and capture fail_addr, fail_elem and fail_data.
  - If the mismatch occurs and stop_on_fail=1, go to DONE next cycle.
- Write with PRE_POST_WRITE_DELAY=0: WR_PULSE only; addr, wdata and we=1 are all presented in the same cycle.
- Write with PRE_POST_WRITE_DELAY=1:
  - WR_SETUP: addr/wdata valid, we=0.
  - WR_PULSE: we=1.
  - WR_HOLD: addr/wdata unchanged, we=0.
- mem_we is high only in WR_PULSE.
- mem_addr/mem_wdata change only in RD_ADDR or in the first write cycle; they never change in the cycle after we=1.
- After the last operation of a word, step the address in the element's direction. After the last word, step to the next element.
- After E5 at address N-1, go to DONE.
- DONE: lasts 1 cycle with done=1, busy=0, then return to IDLE. fail/fail_* hold until the next start.
- busy-high cycle counts, with W = 1 or 3:
  - Full run: N*W + 4*N*(2+W) + 2N.
  - N=16: 240 cycles for delay 0; 400 cycles for delay 1.
- start while busy or in DONE is ignored.
- Only the first mismatch is recorded. Later mismatches leave fail_* unchanged.

Test Plan:
- Fault-free array model, bg=0x00, delay 0, start pulse → busy high exactly 240 cycles; done pulse 1 cycle; fail=0; array ends all 0x00.
- Same with PRE_POST_WRITE_DELAY=1, bg=0xA5 → busy 400 cycles; every mem_we=1 cycle is preceded and followed by a cycle with identical mem_addr/mem_wdata and we=0; fail=0.
- Bit 3 of addr 5 stuck-at-1, bg=0x00, stop_on_fail=0 → fail=1, fail_elem=1, fail_addr=5, fail_data=0x08; busy still 240 cycles.
- Same fault, stop_on_fail=1 → done after 33 busy cycles (16 + 5*3 + 2); fail_addr=5; no mem_we after the failing read.
- Address-order check: log mem_addr over a fault-free run → E3/E4 visit 15..0 and the others 0..15. Coupling fault (write to addr 9 flips addr 8) → first fail reported in E3 at addr 8.
- Assert rst_n=0 during a WR_PULSE cycle (delay 1) → mem_we falls without a clock edge, all outputs 0, no done. start pulsed while busy is ignored: run length unchanged.
